// File: rtl/operand_sel_pipe_if.sv
// -----------------------------------------------------------------------------
// operand_sel_pipe_if
//
// Bundles the request side (decode -> operand selector) and the response side
// (operand selector -> execute) of operand_sel_pipe.
//
//   master : the environment around the selector (drives requests, consumes
//            operands)
//   slave  : the selector itself
//
// Signals
//   in_valid / in_ready    request handshake
//   sel                    0 = immediate, k = GPR source k-1
//   ext_sign               0 = zero-extend immediate, 1 = sign-extend
//   rop                    immediate field
//   gpr                    flattened GPR sources, source k at [k*DATA_W +: DATA_W]
//   out_valid / out_ready  operand handshake
//   data_out               selected, extended operand
//   src_out                sel value that produced data_out
//   sel_err                data_out came from an out-of-range sel
// -----------------------------------------------------------------------------
interface operand_sel_pipe_if #(
  parameter int DATA_W  = 32,
  parameter int IMM_W   = 12,
  parameter int NUM_GPR = 2
);
  localparam int SEL_W = $clog2(NUM_GPR + 1);

  logic                      in_valid;
  logic                      in_ready;
  logic [SEL_W-1:0]          sel;
  logic                      ext_sign;
  logic [IMM_W-1:0]          rop;
  logic [NUM_GPR*DATA_W-1:0] gpr;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W-1:0]         data_out;
  logic [SEL_W-1:0]          src_out;
  logic                      sel_err;

  modport master (
    output in_valid, sel, ext_sign, rop, gpr, out_ready,
    input  in_ready, out_valid, data_out, src_out, sel_err
  );

  modport slave (
    input  in_valid, sel, ext_sign, rop, gpr, out_ready,
    output in_ready, out_valid, data_out, src_out, sel_err
  );
endinterface

// File: rtl/operand_sel_pipe.sv
// -----------------------------------------------------------------------------
// operand_sel_pipe
//
// Registered operand selector for the execute-stage front end. Picks the
// immediate (zero- or sign-extended to DATA_W) or one of NUM_GPR register
// sources, and presents it through a valid/ready output backed by a 2-entry
// buffer (OUT + SKID) so the decode stage keeps full throughput while the
// consumer stalls. Out-of-range selects deliver a zero operand with sel_err.
//
// Ports
//   clk    : single clock, rising edge
//   rst_n  : synchronous reset, active-low
//   bus    : operand_sel_pipe_if.slave (request and operand handshakes)
//
// The interface instance must be built with the same DATA_W / IMM_W /
// NUM_GPR values as this module.
// -----------------------------------------------------------------------------
module operand_sel_pipe #(
  parameter int DATA_W  = 32,
  parameter int IMM_W   = 12,
  parameter int NUM_GPR = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  operand_sel_pipe_if.slave    bus
);

  localparam int SEL_W = $clog2(NUM_GPR + 1);
  localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(NUM_GPR);

  // Buffer occupancy, encoded as {OUT.valid, SKID.valid}. 2'b01 cannot occur
  // because SKID only ever fills while OUT is held.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_FULL  = 2'b11
  } state_t;

  state_t state_reg, state_next;

  logic in_ready_reg;

  logic accept;
  logic consume;
  logic out_valid;
  logic load_out_from_in;
  logic load_out_from_skid;
  logic load_skid;

  // ---------------------------------------------------------------------------
  // Operand formation (combinational, captured at acceptance)
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] gpr_arr [NUM_GPR];
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] operand_next;
  logic              err_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_GPR; gi++) begin : g_unpack
      assign gpr_arr[gi] = bus.gpr[gi*DATA_W +: DATA_W];
    end

    // A zero-width replication is illegal, so the full-width immediate case
    // gets its own branch.
    if (IMM_W == DATA_W) begin : g_imm_full
      assign imm_ext = bus.rop;
    end else begin : g_imm_ext
      assign imm_ext = bus.ext_sign
                     ? {{(DATA_W-IMM_W){bus.rop[IMM_W-1]}}, bus.rop}
                     : {{(DATA_W-IMM_W){1'b0}}, bus.rop};
    end
  endgenerate

  always_comb begin
    operand_next = '0;
    err_next     = 1'b0;
    if (bus.sel == '0) begin
      operand_next = imm_ext;
    end else if (bus.sel > MAX_SEL) begin
      err_next = 1'b1;
    end else begin
      for (int k = 0; k < NUM_GPR; k++) begin
        if (bus.sel == SEL_W'(k + 1)) begin
          operand_next = gpr_arr[k];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  assign accept  = bus.in_valid && in_ready_reg;
  assign consume = out_valid && bus.out_ready;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= ST_EMPTY;
      in_ready_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      // Registered so in_ready never depends combinationally on out_ready.
      in_ready_reg <= (state_next != ST_FULL);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_EMPTY: begin
        if (accept) state_next = ST_ONE;
      end
      ST_ONE: begin
        if (accept && !consume)      state_next = ST_FULL;
        else if (!accept && consume) state_next = ST_EMPTY;
        else                         state_next = ST_ONE;
      end
      ST_FULL: begin
        // in_ready is low here, so only a consume can move us.
        if (consume) state_next = ST_ONE;
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs / datapath steering
  // ---------------------------------------------------------------------------
  always_comb begin
    out_valid          = 1'b0;
    load_out_from_in   = 1'b0;
    load_out_from_skid = 1'b0;
    load_skid          = 1'b0;
    unique case (state_reg)
      ST_EMPTY: begin
        load_out_from_in = accept;
      end
      ST_ONE: begin
        out_valid        = 1'b1;
        load_out_from_in = accept && bus.out_ready;
        load_skid        = accept && !bus.out_ready;
      end
      ST_FULL: begin
        out_valid          = 1'b1;
        load_out_from_skid = bus.out_ready;
        // A beat arriving alongside the drain would land in SKID; with
        // in_ready low in this state that cannot happen, but the steering
        // stays correct if it ever did.
        load_skid          = accept;
      end
      default: begin
        out_valid = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Beat storage
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] out_data_reg,  skid_data_reg;
  logic [SEL_W-1:0]  out_src_reg,   skid_src_reg;
  logic              out_err_reg,   skid_err_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_reg  <= '0;
      out_src_reg   <= '0;
      out_err_reg   <= 1'b0;
      skid_data_reg <= '0;
      skid_src_reg  <= '0;
      skid_err_reg  <= 1'b0;
    end else begin
      // OUT only changes on a load, so it holds under back-pressure and keeps
      // its last value once drained.
      if (load_out_from_skid) begin
        out_data_reg <= skid_data_reg;
        out_src_reg  <= skid_src_reg;
        out_err_reg  <= skid_err_reg;
      end else if (load_out_from_in) begin
        out_data_reg <= operand_next;
        out_src_reg  <= bus.sel;
        out_err_reg  <= err_next;
      end
      if (load_skid) begin
        skid_data_reg <= operand_next;
        skid_src_reg  <= bus.sel;
        skid_err_reg  <= err_next;
      end
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid;
  assign bus.data_out  = out_data_reg;
  assign bus.src_out   = out_src_reg;
  assign bus.sel_err   = out_err_reg;

endmodule
